// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle signed subtractor, diff = a - b - bin.
// One SLICE-bit chunk is added per clock, LSB slice first, as a + ~b + !bin,
// with the inter-slice carry held in a flop. Requires WIDTH = N * SLICE, N >= 2.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the last completed result
// S_RUN  | one slice per cycle; idx_q selects the slice being added
// S_DONE | done pulse; outputs just updated; start here launches the next op
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    // a_q/b_q shift right one slice per RUN cycle, so the active slice is
    // always at the bottom and the last slice carries the operand sign bits.
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE:0]     slice_sum;
    logic               launch;
    logic               last_slice;

    // Next-state, slice datapath and output register computation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        slice_sum  = {1'b0, a_q[SLICE-1:0]} + {1'b0, ~b_q[SLICE-1:0]}
                   + (SLICE+1)'(carry_q);
        last_slice = (idx_q == IDX_W'(N - 1));
        // DONE accepts start so back-to-back operations repeat every N+1 cycles.
        launch     = start && (state_q == S_IDLE || state_q == S_DONE);

        case (state_q)
            S_RUN: begin
                res_d   = {slice_sum[SLICE-1:0], res_q[WIDTH-1:SLICE]};
                carry_d = slice_sum[SLICE];
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                idx_d   = idx_q + 1'b1;
                if (last_slice) begin
                    diff_d  = {slice_sum[SLICE-1:0], res_q[WIDTH-1:SLICE]};
                    bout_d  = ~slice_sum[SLICE];
                    ovf_d   = (a_q[SLICE-1] != b_q[SLICE-1]) &&
                              (slice_sum[SLICE-1] != a_q[SLICE-1]);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            a_d     = a;
            b_d     = b;
            res_d   = '0;
            carry_d = ~bin;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
        end
    end

    // All state registers; reset clears everything and beats start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] prev_diff = '0;
    logic        prev_bout = 1'b0;
    logic        prev_ovf  = 1'b0;

    serial_subtractor #(.WIDTH(32), .SLICE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, bout, diff} from signed/unsigned integer arithmetic.
    function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                            input logic bi);
        longint          sx, sy, full;
        longint unsigned ux, uy;
        logic            o, bo;
        logic [63:0]     fb;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        full = sx - sy - longint'(bi);
        fb   = full;
        o    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        ux   = {32'b0, x};
        uy   = {32'b0, y};
        bo   = (ux < uy + longint'(bi));
        return {o, bo, fb[31:0]};
    endfunction

    task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y,
                                input logic bi);
        logic [33:0] r;
        r = ref_sub(x, y, bi);
        check({tag, ".diff"}, 64'(diff), 64'(r[31:0]));
        check({tag, ".bout"}, 64'(bout), 64'(r[32]));
        check({tag, ".ovf"},  64'(overflow), 64'(r[33]));
        prev_diff = r[31:0];
        prev_bout = r[32];
        prev_ovf  = r[33];
    endtask

    // One operation; hold=1 keeps start high and scrambles a/b during RUN.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic bi, input bit hold);
        int cycles;
        @(negedge clk);
        a = x; b = y; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        check({tag, ".busy0"}, 64'(busy), 64'd1);
        check({tag, ".hold0"}, 64'(diff), 64'(prev_diff));
        if (!hold) start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (hold) begin
                a = $urandom; b = $urandom; bin = 1'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
            if (done !== 1'b1) begin
                check({tag, ".busyrun"}, 64'(busy), 64'd1);
                check({tag, ".holdrun"}, 64'(diff), 64'(prev_diff));
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(cycles), 64'd4);
        check({tag, ".busydone"}, 64'(busy), 64'd1);
        check_result(tag, x, y, bi);
        @(posedge clk); #1;
        check({tag, ".done_off"}, 64'(done), 64'd0);
        check({tag, ".busy_off"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] qa [3];
        logic [31:0] qb [3];
        logic        qc [3];
        int          ndone;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.diff", 64'(diff), 64'd0);
        check("rst.bout", 64'(bout), 64'd0);
        check("rst.ovf",  64'(overflow), 64'd0);

        // Reset beats start in the same cycle.
        @(negedge clk); start = 1'b1; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        check("rst_vs_start.busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0; start = 1'b0;

        run_op("basic",   32'd52, -32'sd31, 1'b0, 1'b0);
        run_op("ovf_neg", 32'h80000000, 32'd1, 1'b0, 1'b0);
        run_op("ovf_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("xslice",  32'h00000100, 32'd1, 1'b0, 1'b0);
        run_op("zero_m1", 32'd0, 32'd1, 1'b0, 1'b0);
        run_op("bin5_3",  32'd5, 32'd3, 1'b1, 1'b0);
        run_op("bin00",   32'd0, 32'd0, 1'b1, 1'b0);
        run_op("hold",    32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);

        // Nothing further after a single accepted start.
        ndone = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("hold.extra_done", 64'(ndone), 64'd0);

        // Back-to-back with start held: done every 5 cycles.
        for (int i = 0; i < 3; i++) begin
            qa[i] = $urandom; qb[i] = $urandom; qc[i] = 1'($urandom);
        end
        @(negedge clk);
        a = qa[0]; b = qb[0]; bin = qc[0]; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            for (int c = 1; c <= 5; c++) begin
                @(posedge clk); #1;
                if (c < 4) check("b2b.nodone", 64'(done), 64'd0);
                if (c == 4) begin
                    check("b2b.done", 64'(done), 64'd1);
                    check_result("b2b", qa[k], qb[k], qc[k]);
                    if (k < 2) begin
                        a = qa[k+1]; b = qb[k+1]; bin = qc[k+1];
                    end else begin
                        start = 1'b0;
                    end
                end
                if (c == 5) begin
                    check("b2b.done_off", 64'(done), 64'd0);
                    check("b2b.busy", 64'(busy), (k < 2) ? 64'd1 : 64'd0);
                    if (k == 2) break;
                end
                if (c == 4 && k == 2) begin
                    @(posedge clk); #1;
                    check("b2b.end_busy", 64'(busy), 64'd0);
                    break;
                end
            end
        end

        // Reset at the 2nd RUN cycle aborts the operation.
        @(negedge clk);
        a = 32'd1000; b = 32'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.diff", 64'(diff), 64'd0);
        check("abort.bout", 64'(bout), 64'd0);
        check("abort.ovf",  64'(overflow), 64'd0);
        @(negedge clk); rst = 1'b0;
        prev_diff = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("abort.no_done", 64'(ndone), 64'd0);
        run_op("after_abort", 32'hFFFFFFF0, 32'h0000000F, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op("rand", $urandom, $urandom, 1'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
